bus_arbiter_n: RTL and testbench

BUS_ARBITER_N -- requirements
Module: bus_arbiter_n

---
 rtl/bus_arbiter_n.sv | 100 ++++++++++
 tb/tb_bus_arbiter_n.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_n.sv
// bus_arbiter_n: arbitrates NCH masters onto one qspi controller port.
// Fixed priority (channel 0 highest) by default; define BUS_ARB_ROUND_ROBIN_EN for round-robin.
module bus_arbiter_n #(
  parameter int NCH = 3,
  parameter int AW  = 32,
  parameter int DW  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    m_req,
  input  logic [NCH-1:0]    m_we,
  input  logic [NCH-1:0]    m_w,
  input  logic [NCH-1:0]    m_hw,
  input  logic [NCH*AW-1:0] m_adr,
  input  logic [NCH*DW-1:0] m_wdata,
  output logic [NCH-1:0]    m_ack,
  output logic [DW-1:0]     m_rdata,
  output logic              s_read_req,
  output logic              s_write_req,
  output logic              s_w,
  output logic              s_hw,
  output logic [AW-1:0]     s_adr,
  output logic [DW-1:0]     s_wdata,
  input  logic              s_done,
  input  logic [DW-1:0]     s_rdata,
  output logic              busy
);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, ACK = 2'd2;
  logic [1:0]     state_q, state_d;
  logic [IW-1:0]  idx_q, win;
  logic           rd_q, wr_q, w_q, hw_q;
  logic [AW-1:0]  adr_q;
  logic [DW-1:0]  wdata_q, rdata_q;
  logic [NCH-1:0] ack_q;
`ifdef BUS_ARB_ROUND_ROBIN_EN
  logic [IW-1:0]  ptr_q;
`endif
  // Descending scan so the last hit is the highest-priority requester.
  always_comb begin
    win = '0;
    for (int i = NCH-1; i >= 0; i--)
`ifdef BUS_ARB_ROUND_ROBIN_EN
      if (m_req[(int'(ptr_q) + i) % NCH]) win = IW'((int'(ptr_q) + i) % NCH);
`else
      if (m_req[i]) win = IW'(i);
`endif
  end
  always_comb begin
    state_d = (state_q == IDLE) ? ((|m_req) ? BUSY : IDLE) :
              (state_q == BUSY) ? (s_done ? ACK : BUSY) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      w_q     <= 1'b0;
      hw_q    <= 1'b0;
      adr_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= '0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ack_q   <= '0;
      if (state_q == IDLE && |m_req) begin
        idx_q   <= win;
        rd_q    <= ~m_we[win];
        wr_q    <= m_we[win];
        w_q     <= m_w[win];
        hw_q    <= m_hw[win] & ~m_w[win];
        adr_q   <= m_adr[int'(win)*AW +: AW];
        wdata_q <= m_wdata[int'(win)*DW +: DW];
`ifdef BUS_ARB_ROUND_ROBIN_EN
        ptr_q   <= (win == IW'(NCH-1)) ? '0 : win + IW'(1);
`endif
      end
      if (state_q == BUSY && s_done) begin
        rd_q  <= 1'b0;
        wr_q  <= 1'b0;
        ack_q <= NCH'(1) << idx_q;
        if (rd_q) rdata_q <= s_rdata;
      end
    end
  end
  assign m_ack       = ack_q;
  assign m_rdata     = rdata_q;
  assign s_read_req  = rd_q;
  assign s_write_req = wr_q;
  assign s_w         = w_q;
  assign s_hw        = hw_q;
  assign s_adr       = adr_q;
  assign s_wdata     = wdata_q;
  assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_bus_arbiter_n.sv
// tb_bus_arbiter_n: randomized scoreboard bench for bus_arbiter_n with a qspi slave model.
module tb_bus_arbiter_n;
  localparam int NCH = 3, AW = 32, DW = 32;
  logic clk = 0, rst_n = 0;
  logic [NCH-1:0] m_req = 0, m_we = 0, m_w = 0, m_hw = 0, m_ack;
  logic [NCH*AW-1:0] m_adr = 0;
  logic [NCH*DW-1:0] m_wdata = 0;
  logic [DW-1:0] m_rdata, s_wdata, s_rdata = 0;
  logic [AW-1:0] s_adr;
  logic s_read_req, s_write_req, s_w, s_hw, s_done = 0, busy;
  bus_arbiter_n #(.NCH(NCH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_we(m_we), .m_w(m_w), .m_hw(m_hw),
    .m_adr(m_adr), .m_wdata(m_wdata), .m_ack(m_ack), .m_rdata(m_rdata),
    .s_read_req(s_read_req), .s_write_req(s_write_req), .s_w(s_w), .s_hw(s_hw),
    .s_adr(s_adr), .s_wdata(s_wdata), .s_done(s_done), .s_rdata(s_rdata), .busy(busy));
  always #5 clk = ~clk;
  typedef struct {
    int ch; bit we, w, hw;
    logic [AW-1:0] adr; logic [DW-1:0] wdata, rdata; int dly;
  } txn_t;
  txn_t exp_q[$], slv_q[$];
  int errors = 0, checks = 0, mptr = 0, stray_req = 0, stray_done = 0;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask
  // Reference grant rule: first requester at or after p, wrapping upward.
  function automatic int pick(input logic [NCH-1:0] mask, input int p);
    for (int k = 0; k < NCH; k++) if (mask[(p + k) % NCH]) return (p + k) % NCH;
    return -1;
  endfunction
  task automatic predict(input logic [NCH-1:0] mask, input int dly, input logic [DW-1:0] rd, input bit fixrd);
    logic [NCH-1:0] rem = mask;
    txn_t t;
    int p;
    while (rem != 0) begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
      p = mptr;
`else
      p = 0;
`endif
      t.ch = pick(rem, p);
      t.we = m_we[t.ch]; t.w = m_w[t.ch]; t.hw = m_hw[t.ch];
      t.adr = m_adr[t.ch*AW +: AW]; t.wdata = m_wdata[t.ch*DW +: DW];
      t.rdata = fixrd ? rd : $urandom;
      t.dly = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
      exp_q.push_back(t);
      slv_q.push_back(t);
      rem[t.ch] = 1'b0;
      mptr = (t.ch + 1) % NCH;
    end
  endtask
  task automatic wait_done();
    int n = 0;
    while ((m_req != 0 || exp_q.size() != 0) && n < 300) begin
      @(negedge clk);
      m_req = m_req & ~m_ack;
      n++;
    end
    if (n >= 300) chk("timeout_wait_done", 64'(n), 0);
  endtask
  task automatic run_batch(input logic [NCH-1:0] mask, input int dly, input logic [DW-1:0] rd, input bit fixrd);
    predict(mask, dly, rd, fixrd);
    m_req = mask;
    wait_done();
  endtask
  // qspi slave: checks presented fields, answers after the scripted delay.
  txn_t cur;
  int cnt = 0;
  bit active = 0;
  always @(negedge clk) begin
    s_done = 1'b0;
    if (!rst_n) active = 0;
    if (stray_done != stray_req) begin
      s_done = 1'b1;
      s_rdata = $urandom;
      stray_done++;
    end else if (rst_n && (s_read_req || s_write_req)) begin
      if (!active) begin
        active = 1;
        if (slv_q.size() == 0) begin
          chk("slave_unexpected_req", {s_read_req, s_write_req}, 0);
          cur.dly = 0; cur.rdata = 0;
        end else begin
          cur = slv_q.pop_front();
          chk("s_dir", {s_read_req, s_write_req}, {~cur.we, cur.we});
          chk("s_adr", s_adr, cur.adr);
          chk("s_w", s_w, cur.w);
          chk("s_hw", s_hw, cur.hw & ~cur.w);
          if (cur.we) chk("s_wdata", s_wdata, cur.wdata);
        end
        cnt = cur.dly;
      end
      if (cnt == 0) begin
        s_done = 1'b1;
        s_rdata = cur.rdata;
        active = 0;
      end else cnt--;
    end
  end
  // Monitor: every ack pops the scoreboard.
  logic [DW-1:0] rd_model = 0;
  txn_t e;
  always @(negedge clk) begin
    if (!rst_n) rd_model = 0;
    else if (m_ack != 0) begin
      if (exp_q.size() == 0) chk("unexpected_ack", m_ack, 0);
      else begin
        e = exp_q.pop_front();
        chk("m_ack", m_ack, NCH'(1) << e.ch);
        if (!e.we) rd_model = e.rdata;
        chk("m_rdata", m_rdata, rd_model);
      end
    end
  end
  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"}, {m_ack, s_read_req, s_write_req, s_w, s_hw, busy}, 0);
    chk({nm, "_data"}, {s_adr, s_wdata}, 0);
    chk({nm, "_rdata"}, m_rdata, 0);
  endtask
  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1;
    @(negedge clk);
    // single read on ch1, s_done in third BUSY cycle
    m_we = 0; m_adr[AW +: AW] = 32'h100;
    predict(3'b010, 2, 32'hDEADBEEF, 1);
    m_req = 3'b010;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) chk("lat_sreq", {s_read_req, s_write_req, busy}, 3'b101);
      m_req = m_req & ~m_ack;
    end while (m_ack == 0 && n < 20);
    chk("ack_latency", 64'(n), 4);
    chk("read_rdata", m_rdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("ack_one_cycle", {m_ack, busy}, 0);
    // simultaneous ch0 write, ch2 read
    m_we = 3'b001; m_wdata[0 +: DW] = 32'hA5A5_0001; m_adr[2*AW +: AW] = 32'h200;
    run_batch(3'b101, -1, 0, 0);
    // all three held for six transactions
    run_batch(3'b111, -1, 0, 0);
    run_batch(3'b111, -1, 0, 0);
    // word wins over halfword, write leaves m_rdata alone
    m_we = 3'b001; m_w = 3'b001; m_hw = 3'b001; m_wdata[0 +: DW] = 32'h12345678;
    run_batch(3'b001, 1, 0, 0);
    m_w = 0; m_hw = 0;
    // stray s_done in IDLE
    @(negedge clk);
    stray_req++;
    repeat (4) begin
      @(negedge clk);
      chk("stray_idle", {m_ack, busy, s_read_req, s_write_req}, 0);
    end
    // request dropped while BUSY still completes
    m_we = 0; m_adr[AW +: AW] = 32'h300;
    predict(3'b010, 3, 0, 0);
    m_req = 3'b010;
    @(negedge clk);
    chk("drop_busy", busy, 1);
    m_req = 0;
    wait_done();
    // reset mid-transaction: no ack, outputs cleared
    @(negedge clk);
    cur.ch = 1; cur.we = 0; cur.w = 0; cur.hw = 0; cur.adr = m_adr[AW +: AW];
    cur.wdata = 0; cur.rdata = 32'hBAD; cur.dly = 8;
    slv_q.push_back(cur);
    m_req = 3'b010;
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    rst_n = 0; m_req = 0;
    exp_q.delete(); slv_q.delete(); mptr = 0;
    stray_req++;
    repeat (3) @(negedge clk);
    chk_zero("reset_mid");
    rst_n = 1;
    @(negedge clk);
    run_batch(3'b110, -1, 0, 0);
    // randomized batches
    for (int i = 0; i < 40; i++) begin
      m_we = NCH'($urandom); m_w = NCH'($urandom); m_hw = NCH'($urandom);
      for (int c = 0; c < NCH; c++) begin
        m_adr[c*AW +: AW] = $urandom;
        m_wdata[c*DW +: DW] = $urandom;
      end
      run_batch(NCH'($urandom_range(1, (1 << NCH) - 1)), -1, 0, 0);
    end
    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size() + slv_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
